// File: rtl/alu.sv
// ============================================================================
// Module   : alu
// Purpose  : Registered 32-bit integer ALU with signed multiply and status
//            flags. The multiplier is built only when ALU_MULT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inp1,
  input  logic [31:0] inp2,
  input  logic [3:0]  code,
  output logic [31:0] outp,
  output logic [31:0] mult_high,
  output logic [31:0] mult_low,
  output logic        zflag,
  output logic        carryflag,
  output logic        ovfflag,
  output logic        signflag
);

  localparam logic [3:0] C_OP_ADD   = 4'b0000;
  localparam logic [3:0] C_OP_SUB   = 4'b0001;
  localparam logic [3:0] C_OP_AND   = 4'b0010;
  localparam logic [3:0] C_OP_MUL   = 4'b0011;
  localparam logic [3:0] C_OP_OR    = 4'b0100;
  localparam logic [3:0] C_OP_XOR   = 4'b0101;
  localparam logic [3:0] C_OP_NOT   = 4'b0110;
  localparam logic [3:0] C_OP_SLL   = 4'b0111;
  localparam logic [3:0] C_OP_SRL   = 4'b1000;
  localparam logic [3:0] C_OP_SRA   = 4'b1001;
  localparam logic [3:0] C_OP_NEG   = 4'b1010;
  localparam logic [3:0] C_OP_SLT   = 4'b1011;
  localparam logic [3:0] C_OP_SLTU  = 4'b1100;
  localparam logic [3:0] C_OP_PASSB = 4'b1101;

  logic [4:0]         w_shamt;
  logic [32:0]        w_add;
  logic [31:0]        w_sub;
  logic [31:0]        w_neg;
  // Shifts carry one extra bit so the last shifted-out bit falls out for free.
  logic [32:0]        w_sll;
  logic [32:0]        w_srl;
  logic signed [32:0] w_sra;

  assign w_shamt = inp2[4:0];
  assign w_add   = {1'b0, inp1} + {1'b0, inp2};
  assign w_sub   = inp1 - inp2;
  assign w_neg   = 32'd0 - inp1;
  assign w_sll   = {1'b0, inp1} << w_shamt;
  assign w_srl   = {inp1, 1'b0} >> w_shamt;
  assign w_sra   = $signed({inp1, 1'b0}) >>> w_shamt;

`ifdef ALU_MULT_EN
  logic signed [63:0] w_prod;
  assign w_prod = $signed(inp1) * $signed(inp2);
`endif

  logic [31:0] w_res;
  logic [31:0] w_hi;
  logic [31:0] w_lo;
  logic        w_c;
  logic        w_v;
  logic        w_z;
  logic        w_s;
  logic        w_known;
  logic        w_mul;

  always_comb begin
    w_res   = '0;
    w_hi    = '0;
    w_lo    = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_known = 1'b1;
    w_mul   = 1'b0;
    case (code)
      C_OP_ADD: begin
        w_res = w_add[31:0];
        w_c   = w_add[32];
        w_v   = (inp1[31] == inp2[31]) && (w_add[31] != inp1[31]);
      end
      C_OP_SUB: begin
        w_res = w_sub;
        w_c   = inp1 < inp2;
        w_v   = (inp1[31] != inp2[31]) && (w_sub[31] != inp1[31]);
      end
      C_OP_AND:   w_res = inp1 & inp2;
`ifdef ALU_MULT_EN
      C_OP_MUL: begin
        w_mul = 1'b1;
        w_hi  = w_prod[63:32];
        w_lo  = w_prod[31:0];
        w_res = w_prod[31:0];
        w_v   = w_prod[63:32] != {32{w_prod[31]}};
      end
`endif
      C_OP_OR:    w_res = inp1 | inp2;
      C_OP_XOR:   w_res = inp1 ^ inp2;
      C_OP_NOT:   w_res = ~inp1;
      C_OP_SLL: begin
        w_res = w_sll[31:0];
        w_c   = w_sll[32];
      end
      C_OP_SRL: begin
        w_res = w_srl[32:1];
        w_c   = w_srl[0];
      end
      C_OP_SRA: begin
        w_res = w_sra[32:1];
        w_c   = w_sra[0];
      end
      C_OP_NEG: begin
        w_res = w_neg;
        w_c   = inp1 != 32'd0;
        w_v   = inp1 == 32'h8000_0000;
      end
      C_OP_SLT:   w_res = {31'd0, $signed(inp1) < $signed(inp2)};
      C_OP_SLTU:  w_res = {31'd0, inp1 < inp2};
      C_OP_PASSB: w_res = inp2;
      default:    w_known = 1'b0;
    endcase
    // mult_high is zero for every non-MUL op, so one test covers both cases.
    w_z = w_known && (w_res == 32'd0) && (w_hi == 32'd0);
    w_s = w_known && (w_mul ? w_hi[31] : w_res[31]);
  end

  logic [31:0] r_outp;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_z;
  logic        r_c;
  logic        r_v;
  logic        r_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outp <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_z    <= 1'b0;
      r_c    <= 1'b0;
      r_v    <= 1'b0;
      r_s    <= 1'b0;
    end else begin
      r_outp <= w_res;
      r_hi   <= w_hi;
      r_lo   <= w_lo;
      r_z    <= w_z;
      r_c    <= w_c;
      r_v    <= w_v;
      r_s    <= w_s;
    end
  end

  assign outp      = r_outp;
  assign mult_high = r_hi;
  assign mult_low  = r_lo;
  assign zflag     = r_z;
  assign carryflag = r_c;
  assign ovfflag   = r_v;
  assign signflag  = r_s;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module   : tb_alu
// Purpose  : Scoreboard bench for alu: directed vectors push expected results,
//            a monitor pops and compares one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] inp1;
  logic [31:0] inp2;
  logic [3:0]  code;
  logic [31:0] outp;
  logic [31:0] mult_high;
  logic [31:0] mult_low;
  logic        zflag;
  logic        carryflag;
  logic        ovfflag;
  logic        signflag;

  alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inp1      (inp1),
    .inp2      (inp2),
    .code      (code),
    .outp      (outp),
    .mult_high (mult_high),
    .mult_low  (mult_low),
    .zflag     (zflag),
    .carryflag (carryflag),
    .ovfflag   (ovfflag),
    .signflag  (signflag)
  );

  typedef struct {
    string       name;
    logic [31:0] o;
    logic [31:0] h;
    logic [31:0] l;
    logic        z;
    logic        c;
    logic        v;
    logic        s;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input exp_t e);
    checks++;
    if (outp !== e.o || mult_high !== e.h || mult_low !== e.l ||
        zflag !== e.z || carryflag !== e.c || ovfflag !== e.v || signflag !== e.s) begin
      errors++;
      $display("FAIL %s: got outp=%h hi=%h lo=%h z=%b c=%b v=%b s=%b, expected outp=%h hi=%h lo=%h z=%b c=%b v=%b s=%b",
               e.name, outp, mult_high, mult_low, zflag, carryflag, ovfflag, signflag,
               e.o, e.h, e.l, e.z, e.c, e.v, e.s);
    end
  endtask

  task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input logic [31:0] eh, input logic [31:0] el,
                       input logic ez, input logic ec, input logic ev, input logic es);
    exp_t e;
    @(negedge clk);
    code = op;
    inp1 = a;
    inp2 = b;
    e.name = nm; e.o = eo; e.h = eh; e.l = el;
    e.z = ez; e.c = ec; e.v = ev; e.s = es;
    q.push_back(e);
  endtask

  task automatic check_zero(input string nm);
    exp_t e;
    e.name = nm; e.o = '0; e.h = '0; e.l = '0;
    e.z = 1'b0; e.c = 1'b0; e.v = 1'b0; e.s = 1'b0;
    compare(e);
  endtask

  // Monitor: every cycle the DUT presents the result of the previous issue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) compare(q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    code  = 4'b0000;
    inp1  = 32'hDEAD_BEEF;
    inp2  = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_hold");
    rst_n = 1'b1;
    #1;
    check_zero("after_release_before_edge");

    //     name              op       inp1          inp2          outp          hi            lo            z  c  v  s
    issue("add_5_7",       4'b0000, 32'd5,        32'd7,        32'd12,       32'd0,        32'd0,        0, 0, 0, 0);
`ifdef ALU_MULT_EN
    issue("mul_m2_4",      4'b0011, 32'hFFFFFFFE, 32'd4,        32'hFFFFFFF8, 32'hFFFFFFFF, 32'hFFFFFFF8, 0, 0, 0, 1);
    issue("mul_ovf",       4'b0011, 32'h00010000, 32'h00010000, 32'd0,        32'd1,        32'd0,        0, 0, 1, 0);
`else
    issue("mul_m2_4_off",  4'b0011, 32'hFFFFFFFE, 32'd4,        32'd0,        32'd0,        32'd0,        0, 0, 0, 0);
    issue("mul_ovf_off",   4'b0011, 32'h00010000, 32'h00010000, 32'd0,        32'd0,        32'd0,        0, 0, 0, 0);
`endif
    issue("add_ovf",       4'b0000, 32'h7FFFFFFF, 32'd1,        32'h80000000, 32'd0,        32'd0,        0, 0, 1, 1);
    issue("add_carry",     4'b0000, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'd0,        1, 1, 0, 0);
    issue("sub_equal",     4'b0001, 32'd9,        32'd9,        32'd0,        32'd0,        32'd0,        1, 0, 0, 0);
    issue("sub_borrow",    4'b0001, 32'd0,        32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,        0, 1, 0, 1);
    issue("sub_ovf",       4'b0001, 32'h80000000, 32'd1,        32'h7FFFFFFF, 32'd0,        32'd0,        0, 0, 1, 0);
    issue("sra_1",         4'b1001, 32'h80000003, 32'd1,        32'hC0000001, 32'd0,        32'd0,        0, 1, 0, 1);
    issue("undef_1110",    4'b1110, 32'h80000003, 32'd1,        32'd0,        32'd0,        32'd0,        0, 0, 0, 0);
    issue("undef_1111",    4'b1111, 32'd0,        32'd0,        32'd0,        32'd0,        32'd0,        0, 0, 0, 0);
    issue("and",           4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'd0,        32'd0,        0, 0, 0, 1);
    issue("or",            4'b0100, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 32'd0,        32'd0,        0, 0, 0, 0);
    issue("xor",           4'b0101, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 32'd0,        32'd0,        0, 0, 0, 0);
    issue("not_0",         4'b0110, 32'd0,        32'd5,        32'hFFFFFFFF, 32'd0,        32'd0,        0, 0, 0, 1);
    issue("sll_1",         4'b0111, 32'h80000001, 32'd1,        32'h00000002, 32'd0,        32'd0,        0, 1, 0, 0);
    issue("sll_amt0",      4'b0111, 32'h80000001, 32'h00000020, 32'h80000001, 32'd0,        32'd0,        0, 0, 0, 1);
    issue("srl_1",         4'b1000, 32'h80000003, 32'd1,        32'h40000001, 32'd0,        32'd0,        0, 1, 0, 0);
    issue("srl_31",        4'b1000, 32'h80000000, 32'd31,       32'h00000001, 32'd0,        32'd0,        0, 0, 0, 0);
    issue("neg_min",       4'b1010, 32'h80000000, 32'd0,        32'h80000000, 32'd0,        32'd0,        0, 1, 1, 1);
    issue("neg_0",         4'b1010, 32'd0,        32'd0,        32'd0,        32'd0,        32'd0,        1, 0, 0, 0);
    issue("neg_1",         4'b1010, 32'd1,        32'd0,        32'hFFFFFFFF, 32'd0,        32'd0,        0, 1, 0, 1);
    issue("slt_true",      4'b1011, 32'hFFFFFFFF, 32'd1,        32'd1,        32'd0,        32'd0,        0, 0, 0, 0);
    issue("sltu_false",    4'b1100, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'd0,        1, 0, 0, 0);
    issue("passb",         4'b1101, 32'd3,        32'h12345678, 32'h12345678, 32'd0,        32'd0,        0, 0, 0, 0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", q.size());
      q.delete();
    end

    // Mid-stream reset: in-flight ADD is discarded and outputs clear at once.
    @(negedge clk);
    code = 4'b0000; inp1 = 32'd1; inp2 = 32'd1;
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset_immediate");
    @(posedge clk);
    #1 check_zero("reset_over_edge");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_zero("release_no_edge");
    issue("add_after_reset", 4'b0000, 32'd1, 32'd1, 32'd2, 32'd0, 32'd0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d results still pending, expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
